// File: rtl/serial_loader.sv
// Serial frame loader: shifts 13-bit LSB-first frames from an sclk/mosi link and
// turns them into instruction/data memory writes, then issues a processor start pulse.
module serial_loader (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_in,
   input  logic       mosi_in,
   input  logic [1:0] mode_in,
   output logic       imem_we,
   output logic       dmem_we,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       done_out,
   output logic       start_out,
   output logic       frame_err
);

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_IMEM = 2'b01;
   localparam logic [1:0] MODE_DMEM = 2'b10;
   localparam logic [1:0] MODE_RUN  = 2'b11;
   localparam logic [3:0] STOP_IDX  = 4'd12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2,
      RUN    = 2'd3
   } state_t;

   state_t      state;
   logic        sclk_q;
   logic [3:0]  bit_cnt;
   logic [12:0] shreg;
   logic [1:0]  frame_mode;
   logic        sample;

   assign sample = sclk_in & ~sclk_q;

   // Loader FSM; strobes and flags are registered so the write appears in the COMMIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sclk_q     <= 1'b0;
         bit_cnt    <= 4'd0;
         shreg      <= 13'd0;
         frame_mode <= 2'b00;
         imem_we    <= 1'b0;
         dmem_we    <= 1'b0;
         wr_addr    <= 4'd0;
         wr_data    <= 8'd0;
         done_out   <= 1'b0;
         start_out  <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sclk_q    <= sclk_in;
         imem_we   <= 1'b0;
         dmem_we   <= 1'b0;
         start_out <= 1'b0;
         case (state)
            IDLE: begin
               if (sample && (mode_in == MODE_IMEM || mode_in == MODE_DMEM)) begin
                  state      <= SHIFT;
                  frame_mode <= mode_in;
                  shreg      <= {12'd0, mosi_in};
                  bit_cnt    <= 4'd1;
                  done_out   <= 1'b0;
               end else if (mode_in == MODE_RUN && done_out) begin
                  state     <= RUN;
                  start_out <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (mode_in != frame_mode) begin
                  state   <= IDLE;
                  bit_cnt <= 4'd0;
                  shreg   <= 13'd0;
               end else if (sample) begin
                  shreg[bit_cnt] <= mosi_in;
                  bit_cnt        <= bit_cnt + 4'd1;
                  // The stop bit is decided as it is sampled so the strobe lands in COMMIT.
                  if (bit_cnt == STOP_IDX) begin
                     state <= COMMIT;
                     if (!mosi_in) begin
                        wr_addr <= shreg[3:0];
                        wr_data <= shreg[11:4];
                        imem_we <= (frame_mode == MODE_IMEM);
                        dmem_we <= (frame_mode == MODE_DMEM);
                        if (shreg[3:0] == 4'hF) begin
                           done_out <= 1'b1;
                        end else begin
                           done_out <= done_out;
                        end
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     state <= SHIFT;
                  end
               end else begin
                  state <= SHIFT;
               end
            end
            COMMIT: begin
               state   <= IDLE;
               bit_cnt <= 4'd0;
            end
            RUN: begin
               if (mode_in == MODE_IDLE) begin
                  state <= IDLE;
               end else begin
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 The block SHALL have: clk  in  1  system clock; all logic on rising edge.
REQ-002 The block SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have: sclk_in  in  1  serial bit clock from the upstream driver, synchronous to clk.
REQ-004 The block SHALL have: mosi_in  in  1  serial data, LSB first.
REQ-005 The block SHALL have: mode_in  in  2  00 idle, 01 instruction load, 10 data load, 11 run request.
REQ-006 The block SHALL have: imem_we  out  1  one-cycle instruction-memory write strobe.
REQ-007 The block SHALL have: dmem_we  out  1  one-cycle data-memory write strobe.
REQ-008 The block SHALL have: wr_addr  out  4  write address.
REQ-009 The block SHALL have: wr_data  out  8  write data.
REQ-010 The block SHALL have: done_out  out  1  phase-complete flag, wired to the driver's done_in.
REQ-011 The block SHALL have: start_out  out  1  one-cycle processor start pulse.
REQ-012 The block SHALL have: frame_err  out  1  sticky error flag for a bad stop bit.

Function
REQ-013 Frame format SHALL be 13 bits, LSB first, with bits[3:0] as address, bits[11:4] as data byte, and bit[12] as stop bit, required to be 0.
REQ-014 Bit sampling SHALL occur on the sclk rising edge: a cycle where sclk_in=1 and the registered copy sclk_q=0; mosi_in SHALL be sampled in that same cycle.
REQ-015 The state machine SHALL have the states IDLE, SHIFT, COMMIT and RUN.
REQ-016 IDLE -> SHIFT SHALL occur on a sampled edge while mode_in is 01 or 10.
REQ-017 On the IDLE -> SHIFT transition, mode_in SHALL be latched as frame mode, the sampled bit SHALL be stored as bit 0, and bit count SHALL be set to 1.
REQ-018 In SHIFT, each sampled edge SHALL store mosi_in at the current bit count and increment the 4-bit bit count.
REQ-019 When the sample at bit index 12 is taken, SHIFT SHALL transition to COMMIT on the next cycle.
REQ-020 In SHIFT, if mode_in differs from the latched frame mode, the partial frame SHALL be discarded, the block SHALL return to IDLE, and no write SHALL occur.
REQ-021 COMMIT SHALL last exactly 1 cycle and SHALL then return to IDLE.
REQ-022 In COMMIT with stop bit 0, wr_addr and wr_data SHALL be driven from the frame, and imem_we (frame mode 01) or dmem_we (frame mode 10) SHALL be 1 for exactly that cycle.
REQ-023 Write latency SHALL be 1 clk cycle after the cycle in which the stop bit is sampled.
REQ-024 wr_addr and wr_data SHALL hold their last committed values until the next commit.
REQ-025 In COMMIT with stop bit 1, no write strobe SHALL be asserted and frame_err SHALL be set to 1; it SHALL stay 1 until reset.
REQ-026 done_out SHALL be set in a successful COMMIT whose address is 4'hF.
REQ-027 done_out SHALL be cleared on the next IDLE -> SHIFT transition.
REQ-028 done_out SHALL hold through mode_in = 00 gaps.
REQ-029 IDLE -> RUN SHALL occur when mode_in = 11 and done_out = 1; start_out SHALL be 1 on the first RUN cycle only.
REQ-030 RUN SHALL hold done_out = 1 and SHALL return to IDLE when mode_in = 00; start_out SHALL not re-fire until RUN has been exited.
REQ-031 mode_in = 11 while done_out = 0 SHALL be ignored; the block SHALL stay in IDLE.
REQ-032 sclk edges while mode_in = 00 or 11 SHALL be ignored.
REQ-033 Write strobes SHALL never both be high, and a COMMIT SHALL never overlap a SHIFT sample; back-to-back frames are guaranteed by the driver's minimum 2-cycle gap.
REQ-034 No memory arrays SHALL exist inside the block; the shift register SHALL be 13 bits.

Reset
REQ-035 rst_n = 0 SHALL force, immediately and asynchronously: state IDLE, bit count 0, shift register 0, sclk_q 0, imem_we 0, dmem_we 0, wr_addr 0, wr_data 0, done_out 0, start_out 0, frame_err 0.
REQ-036 Reset asserted mid-frame SHALL discard the frame, with no write strobe.
REQ-037 After reset release, the first sampled edge under mode 01/10 SHALL start a new frame.

Verification
REQ-038 Mode 01, frame with addr 3 and data 8'hA5 (stop 0) -> imem_we = 1 for one cycle, 1 cycle after the stop sample; wr_addr = 3; wr_data = 8'hA5; dmem_we = 0.
REQ-039 Mode 10, 16 frames with addr 0..15 and data = addr ^ 8'h5A -> 16 dmem_we pulses with matching addr/data; done_out rises in the 16th commit cycle.
REQ-040 Mode 11 applied with done_out = 1 -> start_out pulses once; done_out stays 1; mode 00 -> IDLE, no further start_out.
REQ-041 Frame with stop bit 1 -> no strobe; frame_err = 1 and remains 1 across subsequent good frames.
REQ-042 mode_in switched 01 -> 00 after 7 bits -> no strobe; the next full frame is captured correctly from bit 0.
REQ-043 rst_n pulsed low after 9 bits -> all outputs 0 at once; no strobe; the following frame with addr 5 and data 8'h3C writes correctly.
